// File: rtl/rf_window_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | rf_window_fetch : 2x2 window address generator and capture stage over a 32-entry RF.  |
// | Optional macro RF_WIN_STALL_CNT_EN adds the stall_cnt output.          Rev 1.0        |
// +--------------------------------------------------------------------------------------+
module rf_window_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 3,
  parameter int IMG_H      = 3,
  parameter int STRIDE     = 1,
  parameter int BASE       = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_wr_hold,
  output logic [4:0]            rf_add_1,
  output logic [4:0]            rf_add_2,
  output logic [4:0]            rf_add_3,
  output logic [4:0]            rf_add_4,
  input  logic [DATA_WIDTH-1:0] rf_out1,
  input  logic [DATA_WIDTH-1:0] rf_out2,
  input  logic [DATA_WIDTH-1:0] rf_out3,
  input  logic [DATA_WIDTH-1:0] rf_out4,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [DATA_WIDTH-1:0] win_d0,
  output logic [DATA_WIDTH-1:0] win_d1,
  output logic [DATA_WIDTH-1:0] win_d2,
  output logic [DATA_WIDTH-1:0] win_d3,
`ifdef RF_WIN_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  win_last
);

  localparam int         NCOL   = (IMG_W - 2) / STRIDE + 1;
  localparam int         NROW   = (IMG_H - 2) / STRIDE + 1;
  localparam logic [4:0] C_LAST = 5'((NCOL - 1) * STRIDE);
  localparam logic [4:0] R_LAST = 5'((NROW - 1) * STRIDE);
  localparam logic [4:0] STEP   = 5'(STRIDE);
  localparam logic [4:0] W5     = 5'(IMG_W);
  localparam logic [4:0] B5     = 5'(BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FETCH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [4:0] row;
  logic [4:0] col;
  logic [4:0] row_nxt;
  logic [4:0] col_nxt;
  logic [4:0] a_nxt;
  logic       slot_free;
  logic       final_win;

  always_comb begin
    slot_free = !win_valid || win_ready;
    final_win = (row == R_LAST) && (col == C_LAST);
    if (col == C_LAST) begin
      col_nxt = '0;
      row_nxt = row + STEP;
    end else begin
      col_nxt = col + STEP;
      row_nxt = row;
    end
    a_nxt = B5 + row_nxt * W5 + col_nxt;
  end

  assign rf_wr_hold = busy;

  // Addresses always point at the next window to be captured, so FETCH sees settled read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      row       <= '0;
      col       <= '0;
      rf_add_1  <= '0;
      rf_add_2  <= '0;
      rf_add_3  <= '0;
      rf_add_4  <= '0;
      win_d0    <= '0;
      win_d1    <= '0;
      win_d2    <= '0;
      win_d3    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
            rf_add_1 <= B5;
            rf_add_2 <= B5 + 5'd1;
            rf_add_3 <= B5 + W5;
            rf_add_4 <= B5 + W5 + 5'd1;
          end
        end
        S_LOAD: state <= S_FETCH;
        S_FETCH: begin
          if (slot_free) begin
            win_d0    <= rf_out1;
            win_d1    <= rf_out2;
            win_d2    <= rf_out3;
            win_d3    <= rf_out4;
            win_valid <= 1'b1;
            win_last  <= final_win;
            if (final_win) begin
              state    <= S_DRAIN;
              row      <= '0;
              col      <= '0;
              rf_add_1 <= '0;
              rf_add_2 <= '0;
              rf_add_3 <= '0;
              rf_add_4 <= '0;
            end else begin
              row      <= row_nxt;
              col      <= col_nxt;
              rf_add_1 <= a_nxt;
              rf_add_2 <= a_nxt + 5'd1;
              rf_add_3 <= a_nxt + W5;
              rf_add_4 <= a_nxt + W5 + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (win_valid && win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RF_WIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if ((state == S_FETCH || state == S_DRAIN) && win_valid && !win_ready &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  a_tile_fits: assert property (@(posedge clk) (BASE + IMG_W * IMG_H - 1) <= 31);

endmodule

`default_nettype wire
